mult_seq: RTL
=============

// Module: mult_seq
// PURPOSE
//  Multi-cycle 32x32 shift-add multiplier sequencer for the MiniMIPS ALU path (MULT/MULTU).
//  Captures operands on a start pulse and iterates one add/shift step per cycle.
//  For signed operations it runs on operand magnitudes and applies a sign-fix cycle at the end.
//  Delivers a 64-bit {hi,lo} product to the HI/LO registers with a busy/done handshake.
//  The control unit stalls the pipeline while busy=1.
// PARAMETERS
//  WIDTH   32   operand width; product is 2*WIDTH bits; iteration count = WIDTH
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      synchronous, active-high reset
//  start      in   1      request; sampled only in IDLE or DONE
//  is_signed  in   1      1 = MULT (two's complement), 0 = MULTU; sampled with start
//  op_a       in   WIDTH  multiplicand; sampled with start
//  op_b       in   WIDTH  multiplier; sampled with start
//  busy       out  1      high in RUN and FIX states
//  done       out  1      single-cycle pulse; hi/lo valid from this cycle
//  hi         out  WIDTH  upper product word; held until next accepted start
//  lo         out  WIDTH  lower product word; held until next accepted start
// BEHAVIOUR
//  - Reset: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, neg flag=0.
//  - States and transitions:
//    IDLE -> RUN on start. DONE -> RUN on start, otherwise DONE -> IDLE.
//    RUN: stays for WIDTH cycles, then -> FIX.
//    FIX: exactly 1 cycle, then -> DONE.
//    DONE: exactly 1 cycle.
//  - Accept (start sampled at edge T):
//    mcand <= is_signed ? |op_a| : op_a, held in a WIDTH-bit unsigned register.
//    {acc_hi,acc_lo} <= {0, is_signed ? |op_b| : op_b}.
//    neg <= is_signed & (op_a[MSB] ^ op_b[MSB]).
//    counter <= 0.
//    |0x80000000| = 0x80000000 as unsigned; no overflow.
//  - RUN step, per cycle:
//    sum = acc_lo[0] ? {1'b0,acc_hi} + mcand : {1'b0,acc_hi}, a (WIDTH+1)-bit value.
//    {acc_hi,acc_lo} <= {sum, acc_lo} >> 1.
//    counter increments; RUN exits after counter reaches WIDTH-1.
//  - FIX: if neg, {acc_hi,acc_lo} <= ~{acc_hi,acc_lo} + 1 (64-bit); else unchanged.
//  - Outputs:
//    {hi,lo} are loaded from the accumulator on entry to DONE; done=1 for that one cycle.
//    hi/lo do not change at any other time except reset.
//    Latency: start at edge T, done high in cycle T+WIDTH+2 (T+34 at default).
//  - start while busy=1 is ignored; no queueing, no error.
//  - Operand or is_signed changes after acceptance have no effect.
//  - start in DONE is accepted: done still pulses for the finished op, and busy rises next cycle.
//  - Reset mid-operation aborts to IDLE; hi/lo clear to 0 and no done pulse is produced.
//  - Zero operands still take the full WIDTH cycles; there is no early termination.
// STRUCTURE
//  - Shared package mips_pkg:
//    state encoding localparams S_IDLE=2'd0, S_RUN=2'd1, S_FIX=2'd2, S_DONE=2'd3.
//    MULT/MULTU funct codes 6'h18 / 6'h19, used by the control unit to drive is_signed.
//  - One sub-module: mult_step_add, a (WIDTH+1)-bit conditional adder computing the RUN sum.
//  - FSM, counter, sign handling and HI/LO registers stay in mult_seq.
// TESTING
//  1. MULTU 7 x 6 -> done exactly 34 cycles after start; hi=0x00000000, lo=0x0000002A.
//  2. MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
//  3. MULT -3 x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
//  4. MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000.
//  5. MULT 0xFFFFFFFF x 0xFFFFFFFF -> hi=0, lo=1.
//  6. Start MULTU 3x4; pulse start with 9x9 at cycle 10 -> ignored; done at 34; lo=0x0C.
//  7. Back-to-back: start asserted in the DONE cycle -> busy the next cycle; second result correct.
//  8. Reset at cycle 20 of a run -> next cycle busy=0, hi=lo=0, no done pulse.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MiniMIPS definitions: multiplier FSM state encoding and MULT/MULTU funct codes.
package mips_pkg;

    localparam int unsigned MULT_WIDTH = 32;

    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } mult_state_e;

endpackage

// File: rtl/mult_step_add.sv
// One shift-add step: adds the multiplicand to the upper accumulator half when enabled.
module mult_step_add #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] mcand,
    input  logic             add_en,
    output logic [WIDTH:0]   sum
);

    always_comb begin
        sum = {1'b0, acc_hi};
        if (add_en) begin
            sum = {1'b0, acc_hi} + {1'b0, mcand};
        end
    end

endmodule

// File: rtl/mult_seq.sv
// Multi-cycle shift-add multiplier for MULT/MULTU; works on magnitudes and
// negates the 2*WIDTH-bit product in a final fix cycle for signed operations.
module mult_seq
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned ACC_W = 2 * WIDTH;

    mult_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             neg_q, neg_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   step_sum;

    // Operand magnitudes; |min_int| is representable as an unsigned WIDTH-bit value.
    always_comb begin
        mag_a = op_a;
        mag_b = op_b;
        if (is_signed && op_a[WIDTH-1]) mag_a = ~op_a + WIDTH'(1);
        if (is_signed && op_b[WIDTH-1]) mag_b = ~op_b + WIDTH'(1);
    end

    mult_step_add #(
        .WIDTH (WIDTH)
    ) u_step_add (
        .acc_hi (acc_q[ACC_W-1:WIDTH]),
        .mcand  (mcand_q),
        .add_en (acc_q[0]),
        .sum    (step_sum)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    state_d = S_RUN;
                    mcand_d = mag_a;
                    acc_d   = {WIDTH'(0), mag_b};
                    neg_d   = is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                // Carry out of the step sum shifts into the accumulator MSB.
                acc_d = ACC_W'({step_sum, acc_q[WIDTH-1:0]} >> 1);
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (neg_q) begin
                    acc_d = ~acc_q + ACC_W'(1);
                end
                {hi_d, lo_d} = acc_d;
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_RUN) || (state_d == S_FIX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
